// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the arbiter in front of it.
package alu_pkg;

    // funct3 encodings; ALU op and branch condition share the same code.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    // Selects SUB / SRA variants.
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] res;
        logic        brtaken;
    } alu_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward (mod N), one-hot grant gated by en.
// ptr advances past the winner only when a grant is actually issued.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N-1:0]                          req,
    input  logic                                  en,
    output logic [N-1:0]                          gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  gnt_idx
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;

    // Priority scan in two passes (ptr..N-1, then 0..ptr-1) so all bit selects are constant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
    end

    // One-hot grant, suppressed when the downstream slot cannot take a result.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = en && found && (win == IDW'(i));
        end
    end

    assign gnt_idx = win;

    // Pointer moves just past the granted requester, wrapping at N-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en && found) begin
            if (win == IDW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= win + IDW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters and captures the
// result into a single registered response slot tagged with the requester id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*32-1:0] req_pc_i,
    input  logic [NREQ*32-1:0] req_rs1_i,
    input  logic [NREQ*32-1:0] req_rs2_i,
    input  logic [NREQ*3-1:0] req_funct3_i,
    input  logic [NREQ*7-1:0] req_funct7_i,
    output logic [31:0]       alu_pc_o,
    output logic [31:0]       alu_rs1_o,
    output logic [31:0]       alu_rs2_o,
    output logic [2:0]        alu_funct3_o,
    output logic [6:0]        alu_funct7_o,
    input  logic [31:0]       alu_res_i,
    input  logic              alu_brtaken_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_res_o,
    output logic              rsp_brtaken_o,
    output logic [IDW-1:0]    rsp_id_o
);

    alu_req_t       reqs [NREQ];
    alu_req_t       sel;
    alu_rsp_t       rsp_q;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] id_q;
    logic           valid_q;
    logic           can_accept;
    logic           accept;

    // Unpack the flat per-requester buses into structs.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqs[i].pc     = req_pc_i[i*32 +: 32];
            reqs[i].rs1    = req_rs1_i[i*32 +: 32];
            reqs[i].rs2    = req_rs2_i[i*32 +: 32];
            reqs[i].funct3 = req_funct3_i[i*3 +: 3];
            reqs[i].funct7 = req_funct7_i[i*7 +: 7];
        end
    end

    // A drain and a new accept can share a cycle, so the slot never costs a bubble.
    assign can_accept = !valid_q || rsp_ready_i;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid_i),
        .en      (can_accept),
        .gnt     (req_ready_o),
        .gnt_idx (gnt_idx)
    );

    assign accept = |(req_valid_i & req_ready_o);

    // ALU operands follow the scan winner regardless of can_accept; zero when idle.
    always_comb begin
        sel = '0;
        if (|req_valid_i) begin
            sel = reqs[gnt_idx];
        end
    end

    assign alu_pc_o     = sel.pc;
    assign alu_rs1_o    = sel.rs1;
    assign alu_rs2_o    = sel.rs2;
    assign alu_funct3_o = sel.funct3;
    assign alu_funct7_o = sel.funct7;

    // Response slot: load on accept, clear valid on a bare drain, data holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
            id_q    <= '0;
        end else if (accept) begin
            valid_q       <= 1'b1;
            rsp_q.res     <= alu_res_i;
            rsp_q.brtaken <= alu_brtaken_i;
            id_q          <= gnt_idx;
        end else if (rsp_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o   = valid_q;
    assign rsp_res_o     = rsp_q.res;
    assign rsp_brtaken_o = rsp_q.brtaken;
    assign rsp_id_o      = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance for datapath,
// backpressure and reset, and a 4-requester instance for fairness order.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    // ---------------- 2-requester instance ----------------
    logic [1:0]  v2;
    logic [1:0]  rdy2;
    logic [63:0] pc2, rs1_2, rs2_2;
    logic [5:0]  f3_2;
    logic [13:0] f7_2;
    logic [31:0] a_pc2, a_rs1_2, a_rs2_2;
    logic [2:0]  a_f3_2;
    logic [6:0]  a_f7_2;
    logic [32:0] a_out2;
    logic        rv2, rr2, rb2;
    logic [31:0] rres2;
    logic [0:0]  rid2;

    // ---------------- 4-requester instance ----------------
    logic [3:0]   v4;
    logic [3:0]   rdy4;
    logic [127:0] pc4, rs1_4, rs2_4;
    logic [11:0]  f3_4;
    logic [27:0]  f7_4;
    logic [31:0]  a_pc4, a_rs1_4, a_rs2_4;
    logic [2:0]   a_f3_4;
    logic [6:0]   a_f7_4;
    logic [32:0]  a_out4;
    logic         rv4, rr4, rb4;
    logic [31:0]  rres4;
    logic [1:0]   rid4;

    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7);
        logic [31:0] r;
        logic        br;
        case (f3)
            F3_ADD_SUB: r = (f7 == F7_ALT) ? a - b : a + b;
            F3_SLTU:    r = {31'b0, a < b};
            F3_XOR:     r = a ^ b;
            F3_OR:      r = a | b;
            F3_AND:     r = a & b;
            default:    r = '0;
        endcase
        case (f3)
            F3_BEQ:  br = (a == b);
            F3_BNE:  br = (a != b);
            F3_BLTU: br = (a < b);
            F3_BGEU: br = (a >= b);
            default: br = 1'b0;
        endcase
        return {r, br};
    endfunction

    assign a_out2 = alu_model(a_rs1_2, a_rs2_2, a_f3_2, a_f7_2);
    assign a_out4 = alu_model(a_rs1_4, a_rs2_4, a_f3_4, a_f7_4);

    alu_arbiter #(.NREQ(2)) u2 (
        .clk(clk), .reset(rst),
        .req_valid_i(v2), .req_ready_o(rdy2),
        .req_pc_i(pc2), .req_rs1_i(rs1_2), .req_rs2_i(rs2_2),
        .req_funct3_i(f3_2), .req_funct7_i(f7_2),
        .alu_pc_o(a_pc2), .alu_rs1_o(a_rs1_2), .alu_rs2_o(a_rs2_2),
        .alu_funct3_o(a_f3_2), .alu_funct7_o(a_f7_2),
        .alu_res_i(a_out2[32:1]), .alu_brtaken_i(a_out2[0]),
        .rsp_valid_o(rv2), .rsp_ready_i(rr2),
        .rsp_res_o(rres2), .rsp_brtaken_o(rb2), .rsp_id_o(rid2)
    );

    alu_arbiter #(.NREQ(4)) u4 (
        .clk(clk), .reset(rst),
        .req_valid_i(v4), .req_ready_o(rdy4),
        .req_pc_i(pc4), .req_rs1_i(rs1_4), .req_rs2_i(rs2_4),
        .req_funct3_i(f3_4), .req_funct7_i(f7_4),
        .alu_pc_o(a_pc4), .alu_rs1_o(a_rs1_4), .alu_rs2_o(a_rs2_4),
        .alu_funct3_o(a_f3_4), .alu_funct7_o(a_f7_4),
        .alu_res_i(a_out4[32:1]), .alu_brtaken_i(a_out4[0]),
        .rsp_valid_o(rv4), .rsp_ready_i(rr4),
        .rsp_res_o(rres4), .rsp_brtaken_o(rb4), .rsp_id_o(rid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic [6:0] f7);
        pc2[i*32 +: 32]  = 32'h1000 + 32'(i * 4);
        rs1_2[i*32 +: 32] = a;
        rs2_2[i*32 +: 32] = b;
        f3_2[i*3 +: 3]   = f3;
        f7_2[i*7 +: 7]   = f7;
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        tick();
    endtask

    int seq4 [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        v2 = '0; rr2 = 1'b0; pc2 = '0; rs1_2 = '0; rs2_2 = '0; f3_2 = '0; f7_2 = '0;
        v4 = '0; rr4 = 1'b0; pc4 = '0; rs1_4 = '0; rs2_4 = '0; f3_4 = '0; f7_4 = '0;
        for (int i = 0; i < 4; i++) rs1_4[i*32 +: 32] = 32'(i);

        // Reset state
        #1;
        chk("rst_valid", 64'(rv2), 64'd0);
        chk("rst_res", 64'(rres2), 64'd0);
        chk("rst_br", 64'(rb2), 64'd0);
        chk("rst_id", 64'(rid2), 64'd0);
        chk("rst_ready", 64'(rdy2), 64'd0);
        #6 rst = 1'b1;
        tick();

        // ADD 10+5 from req0
        set2(0, 32'd10, 32'd5, F3_ADD_SUB, 7'd0);
        v2 = 2'b01; rr2 = 1'b1;
        #1;
        chk("add_ready", 64'(rdy2), 64'b01);
        chk("add_alu_rs1", 64'(a_rs1_2), 64'd10);
        tick();
        v2 = 2'b00;
        chk("add_valid", 64'(rv2), 64'd1);
        chk("add_res", 64'(rres2), 64'd15);
        chk("add_id", 64'(rid2), 64'd0);
        chk("add_br", 64'(rb2), 64'd0);

        // Round-robin: req0 SUB 10-5, req1 BEQ 10,10
        do_reset();
        set2(0, 32'd10, 32'd5, F3_ADD_SUB, F7_ALT);
        set2(1, 32'd10, 32'd10, F3_BEQ, 7'd0);
        v2 = 2'b11; rr2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 64'(rdy2), (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            chk("rr_id", 64'(rid2), (k % 2 == 0) ? 64'd0 : 64'd1);
            chk("rr_res", 64'(rres2), (k % 2 == 0) ? 64'd5 : 64'd20);
            chk("rr_br", 64'(rb2), (k % 2 == 0) ? 64'd0 : 64'd1);
        end
        v2 = 2'b00;
        tick();
        chk("rr_drain", 64'(rv2), 64'd0);

        // Backpressure: req1 SLTU 1 < 0xFFFFFFFF
        set2(1, 32'd1, 32'hFFFF_FFFF, F3_SLTU, 7'd0);
        v2 = 2'b10; rr2 = 1'b0;
        #1;
        chk("bp_first_ready", 64'(rdy2), 64'b10);
        tick();
        chk("bp_first_valid", 64'(rv2), 64'd1);
        chk("bp_first_res", 64'(rres2), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_ready", 64'(rdy2), 64'b00);
            tick();
            chk("bp_hold_valid", 64'(rv2), 64'd1);
            chk("bp_hold_res", 64'(rres2), 64'd1);
            chk("bp_hold_id", 64'(rid2), 64'd1);
        end
        rr2 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(rdy2), 64'b10);
        tick();
        chk("bp_release_valid", 64'(rv2), 64'd1);
        chk("bp_release_id", 64'(rid2), 64'd1);
        v2 = 2'b00;
        tick();
        chk("bp_drain", 64'(rv2), 64'd0);

        // Reset mid-operation: accept req0 (ptr -> 1), hold slot, then async reset
        do_reset();
        set2(0, 32'd10, 32'd5, F3_ADD_SUB, 7'd0);
        set2(1, 32'd10, 32'd10, F3_BEQ, 7'd0);
        v2 = 2'b01; rr2 = 1'b1;
        tick();
        v2 = 2'b00; rr2 = 1'b0;
        chk("mid_pre_valid", 64'(rv2), 64'd1);
        chk("mid_pre_res", 64'(rres2), 64'd15);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rv2), 64'd0);
        chk("mid_rst_res", 64'(rres2), 64'd0);
        #1 rst = 1'b1;
        tick();
        v2 = 2'b11; rr2 = 1'b1;
        #1;
        chk("mid_ptr0_ready", 64'(rdy2), 64'b01);
        tick();
        chk("mid_ptr0_id", 64'(rid2), 64'd0);
        chk("mid_ptr0_res", 64'(rres2), 64'd15);

        // Idle: ptr was left at 1, must survive idle cycles
        v2 = 2'b00;
        #1;
        chk("idle_alu", {a_pc2[15:0], a_rs1_2[15:0], a_rs2_2[15:0], 6'b0, a_f3_2, a_f7_2},
            64'd0);
        chk("idle_ready", 64'(rdy2), 64'b00);
        tick();
        tick();
        tick();
        chk("idle_valid", 64'(rv2), 64'd0);
        v2 = 2'b11;
        #1;
        chk("idle_ptr_ready", 64'(rdy2), 64'b10);
        tick();
        chk("idle_ptr_id", 64'(rid2), 64'd1);
        v2 = 2'b00;

        // Fairness on 4 requesters, then drop req2 once ptr reaches 3
        do_reset();
        v4 = 4'b1111; rr4 = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 7) v4 = 4'b1011;
            #1;
            chk("fair_ready", 64'(rdy4), 64'(1) << seq4[k]);
            chk("fair_alu_rs1", 64'(a_rs1_4), 64'(seq4[k]));
            tick();
            chk("fair_id", 64'(rid4), 64'(seq4[k]));
        end
        v4 = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance (pc/rs1/rs2/funct3/funct7 in; res/brtaken out) between NREQ requesters, for example the integer pipe and the branch-resolve unit.
- Each requester uses a valid/ready handshake. Grants are round-robin and starvation-free.
- The ALU result is captured into a single registered response slot tagged with the requester id. The slot is drained by a valid/ready consumer.
- The block sits between issue logic and the `alu` in the execute stage. The `alu` itself is instantiated outside this block.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), width of the requester id.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req_valid_i, input, NREQ, per-requester operation valid.
- req_ready_o, output, NREQ, per-requester accept; one-hot or zero.
- req_pc_i, input, NREQ*32, packed per-requester PC.
- req_rs1_i, input, NREQ*32, packed per-requester operand 1.
- req_rs2_i, input, NREQ*32, packed per-requester operand 2.
- req_funct3_i, input, NREQ*3, packed per-requester funct3.
- req_funct7_i, input, NREQ*7, packed per-requester funct7.
- alu_pc_o, output, 32, operand to the shared alu.
- alu_rs1_o, output, 32, operand to the shared alu.
- alu_rs2_o, output, 32, operand to the shared alu.
- alu_funct3_o, output, 3, operand to the shared alu.
- alu_funct7_o, output, 7, operand to the shared alu.
- alu_res_i, input, 32, result from the shared alu.
- alu_brtaken_i, input, 1, branch-taken from the shared alu.
- rsp_valid_o, output, 1, response slot full.
- rsp_ready_i, input, 1, consumer accepts the response.
- rsp_res_o, output, 32, registered result.
- rsp_brtaken_o, output, 1, registered branch-taken.
- rsp_id_o, output, IDW, index of the requester that owns the response.

Behaviour:
- Reset (reset==0, async):
  - rsp_valid_o=0, rsp_res_o=0, rsp_brtaken_o=0, rsp_id_o=0.
  - Round-robin pointer ptr=0.
  - An in-flight response is discarded. Requesters must not treat a response as delivered unless the rsp handshake completed before reset.
- can_accept = !rsp_valid_o || rsp_ready_i. A drain and a new accept may happen in the same cycle, giving full throughput of one op per cycle.
- Grant (combinational):
  - Scan from index ptr upward, modulo NREQ. The first i with req_valid_i[i]=1 wins.
  - req_ready_o[i] = can_accept && (i == winner). All other bits are 0.
  - req_ready_o never depends on req_valid_i of the same requester except through winner selection. The block must not create a loop through rsp_ready_i back into the alu.
- ALU mux:
  - When a winner exists, the alu_* outputs carry the winner's fields, even if can_accept=0; this keeps the muxing simple.
  - With no valid request, all alu_* outputs are 0.
- Accept: when req_valid_i[i] && req_ready_o[i] at a rising edge:
  - rsp_res_o<=alu_res_i, rsp_brtaken_o<=alu_brtaken_i, rsp_id_o<=i, rsp_valid_o<=1.
  - ptr<=(i+1) mod NREQ.
  - Latency is exactly 1 cycle from accept to rsp_valid_o.
- Drain without accept: rsp_valid_o && rsp_ready_i with no accept gives rsp_valid_o<=0. The data registers hold their last value.
- Backpressure: while rsp_valid_o=1 and rsp_ready_i=0, rsp_* are stable and all req_ready_o=0. ptr does not change.
- A requester must hold its valid and fields stable until accepted; the block does not check this.
- Fairness: a requester that holds valid is accepted within NREQ accepts of other requesters.
- ptr changes only on accept. Idle cycles leave ptr unchanged.
- Wrap-around: when winner = NREQ-1, ptr wraps to 0.
- Single requester: a continuously valid requester with rsp_ready_i=1 is accepted every cycle.

Decomposition:
- alu_pkg holds:
  - funct3 constants: F3_ADD_SUB/BEQ=000, SLL/BNE=001, SLT=010, SLTU=011, XOR/BLT=100, SRL_SRA/BGE=101, OR/BLTU=110, AND/BGEU=111.
  - F7_ALT=0100000.
  - alu_req_t struct {pc, rs1, rs2, funct3, funct7}.
  - alu_rsp_t struct {res, brtaken}.
- Sub-module rr_arbiter (parameter N) contains ptr, priority scan and a one-hot grant. Its ports are clk, reset, req, en (=can_accept), gnt, gnt_idx.
- alu_arbiter holds the muxes and the response register.

Test Plan:
- ADD: after reset, req0 valid with rs1=10, rs2=5, funct3=000, funct7=0, rsp_ready_i=1.
  - req_ready_o=01.
  - Next cycle rsp_valid_o=1, rsp_res_o=15, rsp_id_o=0, rsp_brtaken_o=0.
- Round-robin: both requesters valid for 4 cycles. req0 does SUB 10-5; req1 does BEQ rs1=rs2=10.
  - Grants alternate 0,1,0,1.
  - Responses: res 5/id0, then brtaken=1/id1, repeated.
- Backpressure: rsp_ready_i=0 for 3 cycles with req1 valid (SLTU 1 vs 0xFFFFFFFF).
  - First accept, then req_ready_o=00 for 3 cycles with rsp_res_o=1 held stable.
  - Drain and next accept occur in the same cycle rsp_ready_i rises.
- Fairness, NREQ=4: all valid continuously.
  - Grant order 0,1,2,3,0; ptr wraps.
  - Drop req2 valid: order becomes 3,0,1,3.
- Reset mid-operation: rsp_valid_o=1 and rsp_ready_i=0, then pulse reset low asynchronously between edges.
  - rsp_valid_o and rsp_res_o go to 0 immediately.
  - After release, ptr=0 and req0 has priority.
- Idle: no req valid.
  - alu_* outputs all 0, req_ready_o=0, rsp_valid_o stays 0, ptr unchanged.
